// File: rtl/arc4_sched.sv
// ARC4 top-level sequencer: accepts a key, runs init -> KSA -> PRGA in order,
// and grants the single-port S RAM to exactly one stage at a time.
module arc4_sched #(
  parameter int unsigned KEY_W  = 24,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              rdy,
  input  logic              en,
  input  logic [KEY_W-1:0]  key,
  output logic              init_en,
  output logic              ksa_en,
  output logic              prga_en,
  input  logic              init_rdy,
  input  logic              ksa_rdy,
  input  logic              prga_rdy,
  output logic [KEY_W-1:0]  ksa_key,
  output logic [KEY_W-1:0]  prga_key,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [ADDR_W-1:0] ksa_addr,
  input  logic [ADDR_W-1:0] prga_addr,
  input  logic [DATA_W-1:0] init_din,
  input  logic [DATA_W-1:0] ksa_din,
  input  logic [DATA_W-1:0] prga_din,
  input  logic              init_wren,
  input  logic              ksa_wren,
  input  logic              prga_wren,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_din,
  output logic              s_wren,
  output logic [1:0]        phase
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    INIT_START = 3'd1,
    INIT_RUN   = 3'd2,
    KSA_START  = 3'd3,
    KSA_RUN    = 3'd4,
    PRGA_START = 3'd5,
    PRGA_RUN   = 3'd6
  } state_t;

  localparam logic [1:0] PH_NONE = 2'd0;
  localparam logic [1:0] PH_INIT = 2'd1;
  localparam logic [1:0] PH_KSA  = 2'd2;
  localparam logic [1:0] PH_PRGA = 2'd3;

  state_t           state;
  logic             guard;
  logic [KEY_W-1:0] key_q;

  // Sequencer; guard masks the stage's stale rdy in the first RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rdy   <= 1'b0;
      phase <= PH_NONE;
      guard <= 1'b0;
      key_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          rdy <= 1'b1;
          if (rdy && en) begin
            key_q <= key;
            rdy   <= 1'b0;
            phase <= PH_INIT;
            state <= INIT_START;
          end
        end
        INIT_START: begin
          if (init_rdy) begin
            state <= INIT_RUN;
            guard <= 1'b1;
          end
        end
        INIT_RUN: begin
          if (guard) begin
            guard <= 1'b0;
          end else if (init_rdy) begin
            phase <= PH_KSA;
            state <= KSA_START;
          end
        end
        KSA_START: begin
          if (ksa_rdy) begin
            state <= KSA_RUN;
            guard <= 1'b1;
          end
        end
        KSA_RUN: begin
          if (guard) begin
            guard <= 1'b0;
          end else if (ksa_rdy) begin
            phase <= PH_PRGA;
            state <= PRGA_START;
          end
        end
        PRGA_START: begin
          if (prga_rdy) begin
            state <= PRGA_RUN;
            guard <= 1'b1;
          end
        end
        PRGA_RUN: begin
          if (guard) begin
            guard <= 1'b0;
          end else if (prga_rdy) begin
            phase <= PH_NONE;
            rdy   <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          phase <= PH_NONE;
          guard <= 1'b0;
          rdy   <= 1'b0;
        end
      endcase
    end
  end

  // Start strobes follow the stage's rdy so a stalled start is withheld, not lost.
  always_comb begin
    init_en = 1'b0;
    ksa_en  = 1'b0;
    prga_en = 1'b0;
    case (state)
      INIT_START: init_en = init_rdy;
      KSA_START:  ksa_en  = ksa_rdy;
      PRGA_START: prga_en = prga_rdy;
      default: ;
    endcase
  end

  // Zero-latency RAM mux keyed on the current grant.
  always_comb begin
    s_addr = '0;
    s_din  = '0;
    s_wren = 1'b0;
    case (phase)
      PH_INIT: begin
        s_addr = init_addr;
        s_din  = init_din;
        s_wren = init_wren;
      end
      PH_KSA: begin
        s_addr = ksa_addr;
        s_din  = ksa_din;
        s_wren = ksa_wren;
      end
      PH_PRGA: begin
        s_addr = prga_addr;
        s_din  = prga_din;
        s_wren = prga_wren;
      end
      default: ;
    endcase
  end

  assign ksa_key  = key_q;
  assign prga_key = key_q;

endmodule

// File: tb/tb_arc4_sched.sv
// Bench for arc4_sched: behavioural stage stubs plus a cycle-timeline model
// derived from the stage busy/stall lengths of each run.
module tb_arc4_sched;

  localparam int unsigned KEY_W  = 24;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              rdy, en;
  logic [KEY_W-1:0]  key;
  logic              init_en, ksa_en, prga_en;
  logic              init_rdy, ksa_rdy, prga_rdy;
  logic [KEY_W-1:0]  ksa_key, prga_key;
  logic [ADDR_W-1:0] init_addr, ksa_addr, prga_addr;
  logic [DATA_W-1:0] init_din, ksa_din, prga_din;
  logic              init_wren, ksa_wren, prga_wren;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_din;
  logic              s_wren;
  logic [1:0]        phase;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  arc4_sched #(.KEY_W(KEY_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .en(en), .key(key),
    .init_en(init_en), .ksa_en(ksa_en), .prga_en(prga_en),
    .init_rdy(init_rdy), .ksa_rdy(ksa_rdy), .prga_rdy(prga_rdy),
    .ksa_key(ksa_key), .prga_key(prga_key),
    .init_addr(init_addr), .ksa_addr(ksa_addr), .prga_addr(prga_addr),
    .init_din(init_din), .ksa_din(ksa_din), .prga_din(prga_din),
    .init_wren(init_wren), .ksa_wren(ksa_wren), .prga_wren(prga_wren),
    .s_addr(s_addr), .s_din(s_din), .s_wren(s_wren), .phase(phase)
  );

  always #5 clk = ~clk;

  // Stage stubs: busy for bcfg cycles after consuming en; st delays readiness
  // by that many cycles once the sequencer grants the stage.
  logic        rdy_int [3];
  int unsigned cnt [3];
  int unsigned st [3];
  int unsigned bcfg [3];
  logic [2:0]  sen;

  assign sen      = {prga_en, ksa_en, init_en};
  assign init_rdy = rdy_int[0] && (st[0] == 0);
  assign ksa_rdy  = rdy_int[1] && (st[1] == 0);
  assign prga_rdy = rdy_int[2] && (st[2] == 0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        rdy_int[k] <= 1'b1;
        cnt[k]     <= 0;
        st[k]      <= 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (sen[k]) begin
          rdy_int[k] <= 1'b0;
          cnt[k]     <= bcfg[k];
        end else if (!rdy_int[k]) begin
          if (cnt[k] <= 1) rdy_int[k] <= 1'b1;
          else cnt[k] <= cnt[k] - 1;
        end
        if (int'(phase) == k + 1 && st[k] != 0) st[k] <= st[k] - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic rand_bus();
    init_addr = ADDR_W'($urandom); init_din = DATA_W'($urandom); init_wren = 1'($urandom);
    ksa_addr  = ADDR_W'($urandom); ksa_din  = DATA_W'($urandom); ksa_wren  = 1'($urandom);
    prga_addr = ADDR_W'($urandom); prga_din = DATA_W'($urandom); prga_wren = 1'($urandom);
  endtask

  // Expected RAM port given the granted phase and what the stubs drive now.
  task automatic check_bus(input int unsigned ph);
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    logic              ew;
    ea = '0; ed = '0; ew = 1'b0;
    if (ph == 1) begin ea = init_addr; ed = init_din; ew = init_wren; end
    if (ph == 2) begin ea = ksa_addr;  ed = ksa_din;  ew = ksa_wren;  end
    if (ph == 3) begin ea = prga_addr; ed = prga_din; ew = prga_wren; end
    check("s_addr", 32'(s_addr), 32'(ea));
    check("s_din",  32'(s_din),  32'(ed));
    check("s_wren", 32'(s_wren), 32'(ew));
  endtask

  task automatic check_reset_vals();
    check("rst_rdy",   32'(rdy), 32'd0);
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_en",    32'({init_en, ksa_en, prga_en}), 32'd0);
    check("rst_key",   32'(ksa_key), 32'd0);
    check_bus(0);
  endtask

  // One accepted run. Stage k is busy b[k] cycles and stalls s[k] cycles at
  // its start; cut>0 asserts reset after that many cycles past accept.
  task automatic do_run(input logic [KEY_W-1:0] k, input int unsigned b0, input int unsigned b1,
                        input int unsigned b2, input int unsigned s0, input int unsigned s1,
                        input int unsigned s2, input bit spam, input int unsigned cut);
    int unsigned a1, a2, a3, st2, st3, done, eph;
    a1   = 1 + s0;
    st2  = a1 + b0 + 2;
    a2   = st2 + s1;
    st3  = a2 + b1 + 2;
    a3   = st3 + s2;
    done = a3 + b2 + 2;
    @(negedge clk);
    bcfg[0] = b0; bcfg[1] = b1; bcfg[2] = b2;
    st[0] = s0; st[1] = s1; st[2] = s2;
    en = 1'b1; key = k;
    rand_bus();
    #1;
    check("idle_rdy", 32'(rdy), 32'd1);
    check("idle_phase", 32'(phase), 32'd0);
    check_bus(0);
    for (int c = 1; c <= int'(done); c++) begin
      @(negedge clk);
      en  = spam ? 1'($urandom) : 1'b0;
      key = spam ? KEY_W'($urandom) : key;
      if (spam && c == int'(a2) + 1) begin en = 1'b1; key = '1; end
      rand_bus();
      #1;
      eph = (c < int'(st2)) ? 1 : (c < int'(st3)) ? 2 : (c < int'(done)) ? 3 : 0;
      check("rdy",     32'(rdy),     32'(c >= int'(done)));
      check("phase",   32'(phase),   eph);
      check("init_en", 32'(init_en), 32'(c == int'(a1)));
      check("ksa_en",  32'(ksa_en),  32'(c == int'(a2)));
      check("prga_en", 32'(prga_en), 32'(c == int'(a3)));
      check("ksa_key", 32'(ksa_key), 32'(k));
      check("prga_key", 32'(prga_key), 32'(k));
      check_bus(eph);
      if (cut != 0 && c == int'(cut)) begin
        init_wren = 1'b1; ksa_wren = 1'b1; prga_wren = 1'b1;
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        @(negedge clk);
        check_reset_vals();
        rst_n = 1'b1;
        @(posedge clk);
        break;
      end
    end
    en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; key = '0;
    for (int k = 0; k < 3; k++) bcfg[k] = 1;
    rand_bus();
    repeat (3) begin
      @(negedge clk);
      rand_bus();
      #1;
      check_reset_vals();
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_rdy_before_edge", 32'(rdy), 32'd0);
    @(posedge clk);
    #1;
    check("rel_rdy_after_edge", 32'(rdy), 32'd1);
    check("rel_en", 32'({init_en, ksa_en, prga_en}), 32'd0);

    // Nominal run, then busy spam with an all-ones key during KSA.
    do_run(24'h00033C, 4, 6, 8, 0, 0, 0, 1'b0, 0);
    do_run(24'h00033C, 4, 6, 8, 0, 0, 0, 1'b1, 0);
    // KSA start stalled for 5 cycles after init completes.
    do_run(24'h123456, 3, 4, 2, 0, 5, 0, 1'b0, 0);
    // Reset while KSA is running (two cycles into KSA_RUN), then a clean run.
    do_run(24'hABCDEF, 2, 6, 2, 0, 0, 0, 1'b0, 1 + 2 + 2 + 2);
    do_run(24'h00033C, 4, 6, 8, 0, 0, 0, 1'b0, 0);
    // Randomized runs.
    for (int r = 0; r < 25; r++) begin
      do_run(KEY_W'($urandom), $urandom_range(8, 1), $urandom_range(8, 1), $urandom_range(8, 1),
             $urandom_range(3, 0), $urandom_range(5, 0), $urandom_range(3, 0),
             1'($urandom), 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/arc4_sched.md
# arc4_sched

Top-level sequencer and S-memory arbiter for the ARC4 cipher datapath. Accepts a start request and a key over the rdy/en microprotocol, then runs the three cipher stages in order: init (S[i]=i fill), KSA, then PRGA. It gives exactly one stage at a time ownership of the single-port S RAM, and reports completion.

## Interface
- KEY_W, 24, key width in bits; latched and forwarded unchanged to KSA and PRGA.
- ADDR_W, 8, S RAM address width.
- DATA_W, 8, S RAM data width.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rdy  out  1  high when a new run can be accepted.
- en  in  1  start request; a run is accepted only on a cycle where rdy=1 and en=1.
- key  in  KEY_W  cipher key; sampled on the accept cycle.
- init_en, ksa_en, prga_en  out  1 each  stage start strobes.
- init_rdy, ksa_rdy, prga_rdy  in  1 each  stage ready flags.
- ksa_key, prga_key  out  KEY_W  latched key.
- {init,ksa,prga}_addr  in  ADDR_W  stage RAM address requests.
- {init,ksa,prga}_din  in  DATA_W  stage RAM write data.
- {init,ksa,prga}_wren  in  1  stage RAM write enables.
- s_addr  out  ADDR_W  to S RAM.
- s_din  out  DATA_W  to S RAM.
- s_wren  out  1  to S RAM. Stages read S RAM q directly.
- phase  out  2  current grant: 0 none, 1 init, 2 ksa, 3 prga.

## Operation
- States: IDLE, INIT_START, INIT_RUN, KSA_START, KSA_RUN, PRGA_START, PRGA_RUN.
- **IDLE:** rdy=1. On en=1:
  - latch key into key_q;
  - go to INIT_START;
  - rdy=0 from the next cycle.
- **X_START (X = init/ksa/prga):**
  - X_en = X_rdy (combinational; the strobe is high only while the stage is ready).
  - When X_rdy=1, go to X_RUN. The strobe therefore lasts exactly one cycle.
  - When X_rdy=0, stay in X_START. The strobe is withheld, not lost.
- **X_RUN:**
  - First cycle in the state: X_rdy is ignored (guard cycle; the stage drops rdy on the edge that consumes en).
  - Later cycles: X_rdy=1 moves to the next START state; PRGA_RUN moves to IDLE.
- **Grant:**
  - phase=1 in INIT_*, 2 in KSA_*, 3 in PRGA_*, 0 in IDLE.
  - s_addr, s_din and s_wren are a combinational mux of the granted stage's signals.
  - Non-granted stages' wren is ignored.
  - phase=0 drives s_addr=0, s_din=0, s_wren=0.
- **Key:** ksa_key = prga_key = key_q, stable from accept through return to IDLE. key changes while busy have no effect.
- en=1 while rdy=0 is ignored. It is not queued.
- **Stage order is fixed:** no stage is skipped, and no stage is re-run within one accepted run.

## Timing
- **During reset:**
  - rdy=0, state=IDLE, phase=0;
  - all *_en=0;
  - s_wren=0, s_addr=0, s_din=0;
  - key_q=0.
- rdy rises on the first rising edge after rst_n deasserts. rdy is registered.
- Accept at edge T moves the state to INIT_START for the cycle after T.
  - If init_rdy=1, init_en is high in that cycle.
  - The earliest init_en is therefore one cycle after accept.
- Stage handoff: X_rdy is seen high in X_RUN (not the guard cycle) at cycle U. The next stage's START is at U+1, and its en at U+1 if it is ready.
- Overhead: with all stages ready, total overhead is 1 (accept→INIT_START) plus 1 START cycle per stage, plus 1 guard cycle per stage.
- PRGA completion: prga_rdy high in PRGA_RUN at cycle V gives IDLE and rdy=1 at V+1. A new en at V+1 is accepted.
- RAM path: zero added latency. s_* change in the same cycle as the granted stage's outputs.
- phase changes only on START entry and on IDLE entry.
- **Reset mid-run:**
  - immediate return to reset values;
  - partial S contents are not restored;
  - the next accepted run restarts from init.

## Test plan
- **Reset:**
  - Stimulus: hold rst_n=0 for 3 cycles, then release.
  - Required: rdy=0 and s_wren=0 throughout reset; rdy=1 exactly one edge after release; all *_en=0.
- **Full run with stubs:**
  - Stimulus: stubs ready after 4, 6 and 8 busy cycles; key=24'h00033C.
  - Required: one-cycle init_en, then ksa_en, then prga_en, each one cycle after the previous rdy.
  - Required: ksa_key=prga_key=24'h00033C; rdy returns high at the computed cycle.
- **Arbitration:**
  - Stimulus: during init, the ksa stub drives wren=1, addr=8'hAA; the init stub drives addr=8'h05, din=8'h05, wren=1.
  - Required: s_addr=8'h05, s_din=8'h05, s_wren=1, phase=1.
  - Required: in KSA, init wren=1 does not reach s_wren.
- **Busy/key hold:**
  - Stimulus: en=1 with key=24'hFFFFFF during KSA.
  - Required: no restart; ksa_key unchanged; exactly one prga_en in the run.
- **Stage stall:**
  - Stimulus: ksa_rdy held low for 5 cycles after init completes.
  - Required: remain in KSA_START with ksa_en=0 and phase=2; ksa_en high in the single cycle ksa_rdy rises.
- **Reset mid-KSA:**
  - Stimulus: assert rst_n=0 during KSA_RUN.
  - Required: outputs return to reset values asynchronously; a subsequent run completes normally, starting with init_en.
